// File: rtl/vga_rd_pkg.sv
`default_nettype none
// ============================================================================
// vga_rd_pkg : shared types and constants for the VGA frame-read scheduler
// Revision   : 1.0
// ============================================================================
package vga_rd_pkg;

    localparam int LEN_W     = 9;
    localparam int PIX_CNT_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_CHECK = 3'd2,
        ST_REQ   = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    function automatic int unsigned frame_bytes(input int unsigned pix, input int unsigned bpp);
        return pix * bpp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_rd_sched_if.sv
`default_nettype none
// ============================================================================
// vga_rd_sched_if : DDR3 burst-read request channel plus burst-done pulse
// Revision        : 1.0
// ============================================================================
interface vga_rd_sched_if
    import vga_rd_pkg::*;
#(
    parameter int ADDR_W = 30
) ();

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [LEN_W-1:0]  rd_req_len;
    logic              rd_done;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready, rd_done
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready, rd_done
    );

endinterface
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
// vga_sync_edge : registers a sync strobe and flags its rising edge
// Revision      : 1.0
// ============================================================================
module vga_sync_edge (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic sig,
    output logic      rise
);

    logic r_sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= sig;
        end
    end

    assign rise = sig & ~r_sig_d;

endmodule
`default_nettype wire

// File: rtl/vga_rd_sched.sv
`default_nettype none
// ============================================================================
// vga_rd_sched : per-frame burst-read scheduler feeding the VGA pixel FIFO
// Revision     : 1.0
// ============================================================================
module vga_rd_sched
    import vga_rd_pkg::*;
#(
    parameter int                ADDR_W        = 30,
    parameter logic [ADDR_W-1:0] FB_BASE       = '0,
    parameter int                FRAME_PIX     = 307200,
    parameter int                BYTES_PER_PIX = 4,
    parameter int                BURST_LEN     = 64,
    parameter int                FIFO_DEPTH    = 1024,
    parameter int                FLUSH_CYC     = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        vsync,
    input  wire logic        buf_sel,
    input  wire logic [10:0] fifo_level,
    vga_rd_sched_if.master   rd,
    output logic             fifo_flush,
    output logic             busy
);

    localparam int                   c_fcnt_w      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [c_fcnt_w-1:0]  c_flush_last  = c_fcnt_w'(FLUSH_CYC - 1);
    localparam logic [ADDR_W-1:0]    c_frame_bytes = ADDR_W'(frame_bytes(FRAME_PIX, BYTES_PER_PIX));
    localparam logic [ADDR_W-1:0]    c_bpp         = ADDR_W'(BYTES_PER_PIX);
    localparam logic [PIX_CNT_W-1:0] c_frame_pix   = PIX_CNT_W'(FRAME_PIX);
    localparam logic [PIX_CNT_W-1:0] c_burst_wide  = PIX_CNT_W'(BURST_LEN);
    localparam logic [LEN_W-1:0]     c_burst_len   = LEN_W'(BURST_LEN);
    localparam logic [11:0]          c_fifo_depth  = 12'(FIFO_DEPTH);

    state_t                r_state;
    logic [c_fcnt_w-1:0]   r_flush_cnt;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic [ADDR_W-1:0]     r_cur_addr;
    logic                  r_resync_pend;

    logic                  w_fs;
    logic [PIX_CNT_W-1:0]  w_remain;
    logic [LEN_W-1:0]      w_len;
    logic                  w_fits;
    logic [ADDR_W-1:0]     w_base;
    logic                  w_go_flush;

    vga_sync_edge u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vsync),
        .rise  (w_fs)
    );

    assign w_remain = c_frame_pix - r_pix_cnt;
    assign w_len    = (w_remain < c_burst_wide) ? w_remain[LEN_W-1:0] : c_burst_len;
    // 12-bit sum so a full FIFO plus a full burst cannot wrap
    assign w_fits   = ({1'b0, fifo_level} + 12'(w_len)) <= c_fifo_depth;
    assign w_base   = buf_sel ? (FB_BASE + c_frame_bytes) : FB_BASE;

    // A frame start in REQ/WAIT is deferred until the outstanding burst lands
    assign w_go_flush = ((r_state == ST_IDLE)  && w_fs) ||
                        ((r_state == ST_CHECK) && w_fs) ||
                        ((r_state == ST_WAIT)  && rd.rd_done && (r_resync_pend || w_fs));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_flush_cnt     <= '0;
            r_pix_cnt       <= '0;
            r_cur_addr      <= '0;
            r_resync_pend   <= 1'b0;
            rd.rd_req_valid <= 1'b0;
            rd.rd_req_addr  <= '0;
            rd.rd_req_len   <= '0;
            fifo_flush      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_flush_last) begin
                        fifo_flush <= 1'b0;
                        r_state    <= ST_CHECK;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!w_fs) begin
                        if (r_pix_cnt == c_frame_pix) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else if (w_fits) begin
                            r_state         <= ST_REQ;
                            rd.rd_req_valid <= 1'b1;
                            rd.rd_req_addr  <= r_cur_addr;
                            rd.rd_req_len   <= w_len;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_fs) r_resync_pend <= 1'b1;
                    if (rd.rd_req_ready) begin
                        rd.rd_req_valid <= 1'b0;
                        r_state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_fs) r_resync_pend <= 1'b1;
                    if (rd.rd_done) begin
                        r_pix_cnt  <= r_pix_cnt + PIX_CNT_W'(rd.rd_req_len);
                        r_cur_addr <= r_cur_addr + ADDR_W'(rd.rd_req_len) * c_bpp;
                        r_state    <= ST_CHECK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_go_flush) begin
                r_state       <= ST_FLUSH;
                fifo_flush    <= 1'b1;
                busy          <= 1'b1;
                r_flush_cnt   <= '0;
                r_cur_addr    <= w_base;
                r_pix_cnt     <= '0;
                r_resync_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_rd_sched.sv
`default_nettype none
// ============================================================================
// tb_vga_rd_sched : self-checking bench for vga_rd_sched against a frame model
// Revision        : 1.0
// ============================================================================
module tb_vga_rd_sched;
    import vga_rd_pkg::*;

    localparam int ADDR_W     = 30;
    localparam int FRAME_PIX  = 200;
    localparam int BPP        = 4;
    localparam int BURST_LEN  = 64;
    localparam int FIFO_DEPTH = 256;
    localparam int FLUSH_CYC  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        buf_sel = 1'b0;
    logic [10:0] fifo_level = '0;
    logic        fifo_flush;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vga_rd_sched_if #(.ADDR_W(ADDR_W)) rd ();

    vga_rd_sched #(
        .ADDR_W        (ADDR_W),
        .FB_BASE       ('0),
        .FRAME_PIX     (FRAME_PIX),
        .BYTES_PER_PIX (BPP),
        .BURST_LEN     (BURST_LEN),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .FLUSH_CYC     (FLUSH_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .buf_sel    (buf_sel),
        .fifo_level (fifo_level),
        .rd         (rd.master),
        .fifo_flush (fifo_flush),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs(input logic b);
        buf_sel = b;
        vsync   = 1'b1;
        tick();
        vsync   = 1'b0;
    endtask

    // Runs one frame fetch acting as the DDR port and compares the captured
    // bursts against the frame split into BURST_LEN pieces from 'base'.
    task automatic serve(input logic [ADDR_W-1:0] base, input bit chk_flush,
                         input int stall_n, input bit rnd, input bit toggle_buf,
                         input string tag);
        logic [ADDR_W-1:0] ea[$];
        logic [8:0]        el[$];
        logic [ADDR_W-1:0] ga[$];
        logic [8:0]        gl[$];
        logic [ADDR_W-1:0] pa;
        logic [8:0]        pl;
        int  nflush = 0, gap = 0, stall = 0, dly = 0, done_i = -100;
        bit  pend = 0, seen_valid = 0, prev_v = 0, prev_wait = 0, finished = 0;
        pa = '0;
        pl = '0;
        for (int p = 0; p < FRAME_PIX; p += BURST_LEN) begin
            ea.push_back(base + ADDR_W'(p * BPP));
            el.push_back(9'((FRAME_PIX - p < BURST_LEN) ? FRAME_PIX - p : BURST_LEN));
        end
        for (int i = 0; i < 3000; i++) begin
            if (seen_valid && !busy && !pend) begin
                finished = 1;
                break;
            end
            rd.rd_done = 1'b0;
            if (toggle_buf) buf_sel = 1'($urandom_range(0, 1));
            if (fifo_flush) nflush++;
            else if (!seen_valid && !rd.rd_req_valid && nflush > 0) gap++;
            if (prev_wait) begin
                checks++;
                if (rd.rd_req_valid !== 1'b1 || rd.rd_req_addr !== pa || rd.rd_req_len !== pl) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%0b a=%0d l=%0d expected v=1 a=%0d l=%0d",
                             tag, rd.rd_req_valid, rd.rd_req_addr, rd.rd_req_len, pa, pl);
                end
            end
            if (rd.rd_req_valid && !prev_v) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    stall = stall_n;
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy_during_fetch: got %0b expected 1", tag, busy);
                    end
                    if (chk_flush) begin
                        checks++;
                        if (gap != 1) begin
                            errors++;
                            $display("FAIL %s flush_to_req_gap: got %0d expected 1", tag, gap);
                        end
                    end
                end else begin
                    checks++;
                    if (i - done_i < 2) begin
                        errors++;
                        $display("FAIL %s done_to_req_gap: got %0d expected >=2", tag, i - done_i);
                    end
                end
            end
            if (stall > 0 && rd.rd_req_valid) begin
                rd.rd_req_ready = 1'b0;
                stall--;
            end else begin
                rd.rd_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rd.rd_req_valid && rd.rd_req_ready) begin
                ga.push_back(rd.rd_req_addr);
                gl.push_back(rd.rd_req_len);
                pend = 1;
                dly  = rnd ? int'($urandom_range(0, 4)) : 2;
            end else if (pend) begin
                if (dly == 0) begin
                    rd.rd_done = 1'b1;
                    pend   = 0;
                    done_i = i;
                end else begin
                    dly--;
                end
            end
            prev_v    = rd.rd_req_valid;
            prev_wait = rd.rd_req_valid && !rd.rd_req_ready;
            pa        = rd.rd_req_addr;
            pl        = rd.rd_req_len;
            tick();
        end
        rd.rd_done      = 1'b0;
        rd.rd_req_ready = 1'b1;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s frame_end_timeout: busy=%0b got 0 bursts-done expected busy drop", tag, busy);
        end
        if (chk_flush) begin
            checks++;
            if (nflush != FLUSH_CYC) begin
                errors++;
                $display("FAIL %s flush_len: got %0d expected %0d", tag, nflush, FLUSH_CYC);
            end
        end
        checks++;
        if (ga.size() != ea.size()) begin
            errors++;
            $display("FAIL %s burst_count: got %0d expected %0d", tag, ga.size(), ea.size());
        end
        for (int k = 0; k < ea.size() && k < ga.size(); k++) begin
            checks++;
            if (ga[k] !== ea[k] || gl[k] !== el[k]) begin
                errors++;
                $display("FAIL %s burst%0d: got (%0d,%0d) expected (%0d,%0d)",
                         tag, k, ga[k], gl[k], ea[k], el[k]);
            end
        end
    endtask

    task automatic test_reset();
        rd.rd_req_ready = 1'b1;
        rd.rd_done      = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (rd.rd_req_valid !== 1'b0 || rd.rd_req_addr !== '0 || rd.rd_req_len !== '0) begin
            errors++;
            $display("FAIL reset_req: got v=%0b a=%0d l=%0d expected 0,0,0",
                     rd.rd_req_valid, rd.rd_req_addr, rd.rd_req_len);
        end
        checks++;
        if (fifo_flush !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got flush=%0b busy=%0b expected 0,0", fifo_flush, busy);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (rd.rd_req_valid !== 1'b0 || busy !== 1'b0 || fifo_flush !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_vsync: got v=%0b busy=%0b flush=%0b expected 0,0,0",
                     rd.rd_req_valid, busy, fifo_flush);
        end
    endtask

    task automatic test_first_frame();
        pulse_fs(1'b0);
        serve(30'd0, 1, 0, 0, 0, "frame0");
    endtask

    task automatic test_buf1();
        pulse_fs(1'b1);
        serve(30'(FRAME_PIX * BPP), 1, 0, 0, 1, "buf1");
    endtask

    task automatic test_throttle();
        bit bad = 0;
        fifo_level = 11'd200;
        pulse_fs(1'b0);
        repeat (20) begin
            if (rd.rd_req_valid) bad = 1;
            tick();
        end
        checks++;
        if (bad || busy !== 1'b1) begin
            errors++;
            $display("FAIL throttle_hold: got req_seen=%0b busy=%0b expected 0,1", bad, busy);
        end
        fifo_level = 11'd192;
        tick();
        checks++;
        if (rd.rd_req_valid !== 1'b1 || rd.rd_req_addr !== '0 || rd.rd_req_len !== 9'd64) begin
            errors++;
            $display("FAIL throttle_release: got v=%0b a=%0d l=%0d expected 1,0,64",
                     rd.rd_req_valid, rd.rd_req_addr, rd.rd_req_len);
        end
        fifo_level = 11'd0;
        serve(30'd0, 0, 0, 0, 0, "throttle");
    endtask

    task automatic test_stall();
        pulse_fs(1'b0);
        serve(30'd0, 1, 10, 0, 0, "stall");
    endtask

    task automatic test_resync();
        bit got = 0, bad = 0;
        rd.rd_req_ready = 1'b1;
        pulse_fs(1'b0);
        for (int i = 0; i < 20 && !got; i++) begin
            if (rd.rd_req_valid) got = 1;
            else tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resync_first_req: got no request expected one within 20 cycles");
        end
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (3) begin
            if (rd.rd_req_valid || fifo_flush) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL resync_wait_quiet: got activity before rd_done expected none");
        end
        rd.rd_done = 1'b1;
        tick();
        rd.rd_done = 1'b0;
        serve(30'd0, 1, 0, 0, 0, "resync");
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        rd.rd_req_ready = 1'b0;
        pulse_fs(1'b1);
        for (int i = 0; i < 20 && !got; i++) begin
            if (rd.rd_req_valid) got = 1;
            else tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!got || rd.rd_req_valid !== 1'b0 || rd.rd_req_addr !== '0 || rd.rd_req_len !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got seen=%0b v=%0b a=%0d l=%0d busy=%0b expected 1,0,0,0,0",
                     got, rd.rd_req_valid, rd.rd_req_addr, rd.rd_req_len, busy);
        end
        #2 rst_n = 1'b1;
        rd.rd_req_ready = 1'b1;
        tick();
        pulse_fs(1'b0);
        serve(30'd0, 1, 0, 0, 0, "post_reset");
    endtask

    task automatic test_random();
        logic b;
        for (int f = 0; f < 4; f++) begin
            b = 1'($urandom_range(0, 1));
            pulse_fs(b);
            serve(b ? 30'(FRAME_PIX * BPP) : 30'd0, 1, 0, 1, 1, "random");
            repeat (int'($urandom_range(1, 5))) tick();
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_buf1();
        test_throttle();
        test_stall();
        test_resync();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
